trb_st2bus_pack: RTL and testbench

TRB_ST2BUS_PACK -- requirements
Module: trb_st2bus_pack

---
 rtl/trb_pkg.sv | 18 +
 rtl/trb_byte_packer.sv | 58 +++++
 rtl/trb_st2bus_pack.sv | 127 ++++++++++++
 tb/tb_trb_st2bus_pack.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/trb_pkg.sv
// trb_pkg -- shared constants and FSM state type for the turbo stream-to-bus packer.
//   ST            : decoded stream byte width in bits
//   BUS           : packed output word width in bits
//   BYTES_PER_PKT : decoded bytes per turbo packet (1024 bits)
//   WORDS_PER_PKT : full bus words per packet
package trb_pkg;
    localparam int ST             = 8;
    localparam int BUS            = 512;
    localparam int BYTES_PER_PKT  = 128;
    localparam int BYTES_PER_WORD = BUS / ST;
    localparam int WORDS_PER_PKT  = BYTES_PER_PKT / BYTES_PER_WORD;  // 2

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/trb_byte_packer.sv
// trb_byte_packer -- word assembly buffer with byte index.
// Each written byte lands at byte lane idx (or lane 0 on restart). On 'done'
// the buffer and index are cleared, so the index wraps to 0 on the byte that
// completes a word.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   wr         : write data into the buffer this cycle
//   restart    : treat the buffer as empty before this write (new packet)
//   done       : this write completes the word; clear buffer and index after it
//   data       : byte to write
//   full       : this write lands in the last byte lane
//   word_cur   : buffer contents before this write
//   word_new   : buffer contents including this write
module trb_byte_packer #(
    parameter int ST  = 8,
    parameter int BUS = 512
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr,
    input  logic           restart,
    input  logic           done,
    input  logic [ST-1:0]  data,
    output logic           full,
    output logic [BUS-1:0] word_cur,
    output logic [BUS-1:0] word_new
);
    localparam int NB = BUS / ST;
    localparam int IW = $clog2(NB);

    logic [BUS-1:0] acc;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  pos;

    assign pos      = restart ? '0 : idx;
    assign full     = (pos == IW'(NB - 1));
    assign word_cur = acc;

    always_comb begin
        word_new = restart ? '0 : acc;
        word_new[pos*ST +: ST] = data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            idx <= '0;
        end else if (wr) begin
            if (done) begin
                acc <= '0;
                idx <= '0;
            end else begin
                acc <= word_new;
                idx <= pos + 1'b1;
            end
        end
    end
endmodule

// File: rtl/trb_st2bus_pack.sv
// trb_st2bus_pack -- packs decoded turbo bytes into BUS-wide host words.
// Packets are framed by st_sop/st_eop; a packet ends on eop, on a sop inside
// the packet, or (with error checking) after BYTES_PER_PKT bytes. The final
// word of a packet is flagged with bus_last; unfilled lanes are zero.
// Optional feature: define TRB_PACK_ERR_CHK_EN to enable framing-error
// counting on err_cnt; otherwise err_cnt is tied to 0.
// Ports:
//   clk_st, rst_n                       : clock, synchronous active-low reset
//   st_data, st_valid, st_sop, st_eop   : byte stream in
//   st_ready                            : byte accepted when st_valid & st_ready
//   bus_data, bus_en, bus_last          : packed word out
//   bus_ready                           : word accepted when bus_en & bus_ready
//   err_cnt                             : saturating framing-error count
module trb_st2bus_pack #(
    parameter int ST            = trb_pkg::ST,
    parameter int BUS           = trb_pkg::BUS,
    parameter int BYTES_PER_PKT = trb_pkg::BYTES_PER_PKT
) (
    input  logic           clk_st,
    input  logic           rst_n,
    input  logic [ST-1:0]  st_data,
    input  logic           st_valid,
    input  logic           st_sop,
    input  logic           st_eop,
    output logic           st_ready,
    output logic [BUS-1:0] bus_data,
    output logic           bus_en,
    output logic           bus_last,
    input  logic           bus_ready,
    output logic [15:0]    err_cnt
);
    import trb_pkg::*;

    state_t         state;
    logic           accept, in_pkt;
    logic           start, sop_fill, cont;
    logic           late, close_new, load_new, load;
    logic           pk_full;
    logic [BUS-1:0] pk_cur, pk_new;

    // The output register is free when empty or emptying this cycle, so any
    // accepted byte may load it.
    assign st_ready = !bus_en || bus_ready;
    assign accept   = st_valid && st_ready;
    assign in_pkt   = (state == FILL);

    // DRAIN behaves like IDLE for incoming bytes: bus_en is always 1 there,
    // so an accepted byte implies the final word is transferring.
    assign start    = accept &&  st_sop && !in_pkt;
    assign sop_fill = accept &&  st_sop &&  in_pkt;
    assign cont     = accept && !st_sop &&  in_pkt;

    // A sop inside a packet takes priority; an eop on that same byte is not
    // acted on, the new packet simply continues.
    assign close_new = (start || cont) && (st_eop || late);
    assign load_new  = (start || cont) && (pk_full || close_new);
    assign load      = load_new || sop_fill;

    trb_byte_packer #(.ST(ST), .BUS(BUS)) u_packer (
        .clk      (clk_st),
        .rst_n    (rst_n),
        .wr       (start || cont || sop_fill),
        .restart  (start || sop_fill),
        .done     (load_new),
        .data     (st_data),
        .full     (pk_full),
        .word_cur (pk_cur),
        .word_new (pk_new)
    );

    always_ff @(posedge clk_st) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus_en   <= 1'b0;
            bus_last <= 1'b0;
            bus_data <= '0;
        end else begin
            if (load) begin
                bus_en   <= 1'b1;
                // sop inside a packet flushes what was buffered before it,
                // even an empty word, so the host still sees bus_last.
                bus_data <= sop_fill ? pk_cur : pk_new;
                bus_last <= sop_fill || close_new;
            end else if (bus_ready) begin
                bus_en <= 1'b0;
            end

            case (state)
                IDLE:  if (start) state <= close_new ? DRAIN : FILL;
                FILL:  if (close_new) state <= DRAIN;
                DRAIN: begin
                    if (start)                    state <= close_new ? DRAIN : FILL;
                    else if (bus_en && bus_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRB_PACK_ERR_CHK_EN
    localparam int CW = $clog2(BYTES_PER_PKT + 1);

    logic [CW-1:0] pkt_cnt, cnt_next;
    logic          drop, early, err_inc;

    assign drop     = accept && !st_sop && !in_pkt;
    assign cnt_next = (start || sop_fill) ? CW'(1) :
                      (&pkt_cnt)          ? pkt_cnt : pkt_cnt + 1'b1;
    assign early    = (start || cont) &&  st_eop && (cnt_next < CW'(BYTES_PER_PKT));
    assign late     = (start || cont) && !st_eop && (cnt_next == CW'(BYTES_PER_PKT));
    // The four error sources are mutually exclusive within a cycle.
    assign err_inc  = drop || early || late || sop_fill;

    always_ff @(posedge clk_st) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (start || cont || sop_fill) pkt_cnt <= cnt_next;
            if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign late    = 1'b0;
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_trb_st2bus_pack.sv
// tb_trb_st2bus_pack -- directed bench for trb_st2bus_pack (ST=8, BUS=512).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Honours TRB_PACK_ERR_CHK_EN for err_cnt expectations.
module tb_trb_st2bus_pack;
    logic         clk_st = 1'b0;
    logic         rst_n;
    logic [7:0]   st_data;
    logic         st_valid, st_sop, st_eop, st_ready;
    logic [511:0] bus_data;
    logic         bus_en, bus_last, bus_ready;
    logic [15:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int exp_err     = 0;
    int acc_cnt     = 0;
    int stall_cnt   = 0;
    logic [511:0] wq[$];
    logic         lq[$];

    trb_st2bus_pack dut (
        .clk_st(clk_st), .rst_n(rst_n), .st_data(st_data), .st_valid(st_valid),
        .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready), .bus_data(bus_data),
        .bus_en(bus_en), .bus_last(bus_last), .bus_ready(bus_ready), .err_cnt(err_cnt)
    );

    always #5 clk_st = ~clk_st;

    // Word/byte monitor: values are stable at the falling edge.
    always @(negedge clk_st) begin
        if (rst_n && bus_en && bus_ready) begin
            wq.push_back(bus_data);
            lq.push_back(bus_last);
        end
        if (rst_n && st_valid && st_ready)  acc_cnt++;
        if (rst_n && st_valid && !st_ready) stall_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_word(input int base, input int n);
        logic [511:0] w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = 8'(base + k);
        return w;
    endfunction

    task automatic chk_word(input string tag, input int i, input int base, input int n, input logic last);
        logic [511:0] d = 'x;
        logic         l = 1'bx;
        if (i < wq.size()) begin d = wq[i]; l = lq[i]; end
        chk({tag, "_data"}, d, mk_word(base, n));
        chk({tag, "_last"}, {511'd0, l}, {511'd0, last});
    endtask

    task automatic send(input logic [7:0] d, input logic sop, input logic eop);
        int guard = 0;
        st_data = d; st_sop = sop; st_eop = eop; st_valid = 1'b1;
        @(negedge clk_st);
        while (!st_ready && guard < 1000) begin
            @(negedge clk_st);
            guard++;
        end
        if (guard >= 1000) begin
            vectors++; miscompares++;
            $error("FAIL send_timeout observed=stalled expected=accept");
        end
        @(posedge clk_st); #1;
    endtask

    task automatic send_pkt(input int base, input int n);
        for (int i = 0; i < n; i++) send(8'(base + i), i == 0, i == n - 1);
    endtask

    task automatic idle(input int n);
        st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
        repeat (n) begin @(posedge clk_st); #1; end
    endtask

    initial begin
        int w0, a0, s0;
        logic hold_ok;
        rst_n = 1'b0; st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
        bus_ready = 1'b1;
        repeat (3) begin @(posedge clk_st); #1; end
        rst_n = 1'b1;
        @(negedge clk_st);
        chk("rst_bus_en",   bus_en, 0);
        chk("rst_bus_last", bus_last, 0);
        chk("rst_bus_data", bus_data, 0);
        chk("rst_err_cnt",  err_cnt, 0);
        chk("rst_st_ready", st_ready, 1);
        @(posedge clk_st); #1;

        // 1: 128-byte packet, host always ready
        w0 = wq.size();
        for (int i = 0; i < 128; i++) begin
            send(8'(i), i == 0, i == 127);
            if (i == 62)  chk("t1_en_b62", bus_en, 0);
            if (i == 63) begin
                chk("t1_en_b63", bus_en, 1);
                chk("t1_w0_live", bus_data, mk_word(0, 64));
                chk("t1_w0_last_live", bus_last, 0);
            end
            if (i == 127) begin
                chk("t1_en_b127", bus_en, 1);
                chk("t1_w1_last_live", bus_last, 1);
            end
        end
        idle(3);
        chk("t1_words", wq.size() - w0, 2);
        chk_word("t1_w0", w0, 8'h00, 64, 1'b0);
        chk_word("t1_w1", w0 + 1, 8'h40, 64, 1'b1);
        chk("t1_err", err_cnt, 16'(exp_err));

        // 2: host back-pressure for 20 cycles on word0
        w0 = wq.size(); a0 = acc_cnt;
        for (int i = 0; i < 64; i++) send(8'(i), i == 0, 1'b0);
        bus_ready = 1'b0;
        st_data = 8'd64; st_sop = 1'b0; st_eop = 1'b0; st_valid = 1'b1;
        hold_ok = 1'b1;
        repeat (20) begin
            @(negedge clk_st);
            hold_ok &= (bus_en === 1'b1) && (bus_data === mk_word(0, 64)) && (st_ready === 1'b0);
            @(posedge clk_st); #1;
        end
        chk("t2_hold", hold_ok, 1);
        bus_ready = 1'b1;
        for (int i = 64; i < 128; i++) send(8'(i), 1'b0, i == 127);
        idle(3);
        chk("t2_bytes", acc_cnt - a0, 128);
        chk("t2_words", wq.size() - w0, 2);
        chk_word("t2_w0", w0, 8'h00, 64, 1'b0);
        chk_word("t2_w1", w0 + 1, 8'h40, 64, 1'b1);

        // 3: 70-byte packet, early eop
        w0 = wq.size();
        send_pkt(0, 70);
        idle(3);
`ifdef TRB_PACK_ERR_CHK_EN
        exp_err += 1;
`endif
        chk("t3_words", wq.size() - w0, 2);
        chk_word("t3_w0", w0, 8'h00, 64, 1'b0);
        chk_word("t3_w1", w0 + 1, 8'h40, 6, 1'b1);
        chk("t3_err", err_cnt, 16'(exp_err));

        // 4: 3 stray bytes in IDLE, then a good packet
        w0 = wq.size();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'hCC, 1'b0, 1'b0);
        send_pkt(8'h80, 128);
        idle(3);
`ifdef TRB_PACK_ERR_CHK_EN
        exp_err += 3;
`endif
        chk("t4_words", wq.size() - w0, 2);
        chk_word("t4_w0", w0, 8'h80, 64, 1'b0);
        chk_word("t4_w1", w0 + 1, 8'hC0, 64, 1'b1);
        chk("t4_err", err_cnt, 16'(exp_err));

        // 5: back-to-back packets, st_valid and bus_ready held high
        w0 = wq.size(); s0 = stall_cnt;
        send_pkt(8'h00, 128);
        send_pkt(8'h80, 128);
        idle(3);
        chk("t5_stalls", stall_cnt - s0, 0);
        chk("t5_words", wq.size() - w0, 4);
        chk_word("t5_w0", w0,     8'h00, 64, 1'b0);
        chk_word("t5_w1", w0 + 1, 8'h40, 64, 1'b1);
        chk_word("t5_w2", w0 + 2, 8'h80, 64, 1'b0);
        chk_word("t5_w3", w0 + 3, 8'hC0, 64, 1'b1);
        chk("t5_err", err_cnt, 16'(exp_err));

        // 6: reset after byte 40 mid-packet
        w0 = wq.size();
        for (int i = 0; i <= 40; i++) send(8'(i), i == 0, 1'b0);
        rst_n = 1'b0; st_valid = 1'b0; st_sop = 1'b0;
        @(posedge clk_st); #1;
        rst_n = 1'b1;
        exp_err = 0;
        @(negedge clk_st);
        chk("t6_en",   bus_en, 0);
        chk("t6_data", bus_data, 0);
        chk("t6_err",  err_cnt, 0);
        @(posedge clk_st); #1;
        idle(3);
        chk("t6_no_word", wq.size() - w0, 0);
        send_pkt(8'h20, 128);
        idle(3);
        chk("t6_words", wq.size() - w0, 2);
        chk_word("t6_w0", w0,     8'h20, 64, 1'b0);
        chk_word("t6_w1", w0 + 1, 8'h60, 64, 1'b1);
        chk("t6_err_end", err_cnt, 16'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
